// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM encoding and field-position helpers for the pipeline control unit.
package pipe_ctrl_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_MULT = 5'd6;
    localparam logic [4:0] ALU_DIV  = 5'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Fields are packed downwards from the opcode: op, rd, rs, rt.
    function automatic int op_lsb(input int insn_w);
        return insn_w - 5;
    endfunction

    function automatic int rd_lsb(input int insn_w, input int reg_w);
        return insn_w - 5 - reg_w;
    endfunction

    function automatic int rs_lsb(input int insn_w, input int reg_w);
        return insn_w - 5 - 2 * reg_w;
    endfunction

    function automatic int rt_lsb(input int insn_w, input int reg_w);
        return insn_w - 5 - 3 * reg_w;
    endfunction

    function automatic logic op_uses_imm(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    // Jump-format instructions carry no rs field.
    function automatic logic op_is_jump(input logic [4:0] op);
        return (op == OP_J) || (op == OP_JAL) || (op == OP_JR) ||
               (op == OP_SETX) || (op == OP_BEX);
    endfunction

    function automatic logic op_reads_rd(input logic [4:0] op);
        return (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);
    endfunction

    function automatic logic op_no_regwrite(input logic [4:0] op);
        return (op == OP_SW) || (op == OP_J) || (op == OP_JR) ||
               (op == OP_BNE) || (op == OP_BLT) || (op == OP_BEX);
    endfunction

endpackage

// File: rtl/md_handshake_fsm.sv
// Mult/div handshake: start pulse, busy tracking with timeout, result-valid pulse and sticky error.
module md_handshake_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic start_req,
    input  logic md_ready,
    output logic md_start,
    output logic md_busy,
    output logic md_wb_valid,
    output logic md_error
);

    localparam int TMO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

    md_state_e        state;
    logic [TMO_W-1:0] tmo_cnt;

    // md_ready is only honoured in BUSY; it wins over a timeout in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= MD_IDLE;
            tmo_cnt     <= '0;
            md_start    <= 1'b0;
            md_busy     <= 1'b0;
            md_wb_valid <= 1'b0;
            md_error    <= 1'b0;
        end else begin
            md_start    <= 1'b0;
            md_wb_valid <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start_req) begin
                        state    <= MD_BUSY;
                        tmo_cnt  <= '0;
                        md_start <= 1'b1;
                        md_busy  <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (md_ready) begin
                        state       <= MD_DONE;
                        md_busy     <= 1'b0;
                        md_wb_valid <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state    <= MD_IDLE;
                        md_busy  <= 1'b0;
                        md_error <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                MD_DONE: begin
                    state <= MD_IDLE;
                end
                default: begin
                    state   <= MD_IDLE;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control/hazard unit: IR decode, load-use stall, branch flush, mult/div handshake and stall counting.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int INSN_W      = 32,
    parameter int REG_W       = 5,
    parameter int MD_TIMEOUT  = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INSN_W-1:0]      fd_ir,
    input  logic [INSN_W-1:0]      dx_ir,
    input  logic [INSN_W-1:0]      xm_ir,
    input  logic [INSN_W-1:0]      mw_ir,
    input  logic                   branch_taken,
    input  logic                   md_ready,
    output logic [4:0]             alu_op,
    output logic                   dx_imm_sel,
    output logic                   datamem_we,
    output logic                   mw_load_sel,
    output logic                   regfile_we,
    output logic                   sw_fd_sel,
    output logic                   wb_rd_zero,
    output logic                   stall_fd,
    output logic                   bubble_dx,
    output logic                   flush,
    output logic                   md_start,
    output logic                   md_busy,
    output logic                   md_wb_valid,
    output logic                   md_error,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int OP_LSB = op_lsb(INSN_W);
    localparam int RD_LSB = rd_lsb(INSN_W, REG_W);
    localparam int RS_LSB = rs_lsb(INSN_W, REG_W);
    localparam int RT_LSB = rt_lsb(INSN_W, REG_W);

    logic [4:0]       fd_op, dx_op, xm_op, mw_op;
    logic [4:0]       dx_alu_field;
    logic [REG_W-1:0] fd_rd, fd_rs, fd_rt, dx_rd, mw_rd;
    logic             load_use, dx_is_md, start_req;

    assign fd_op        = fd_ir[OP_LSB +: 5];
    assign dx_op        = dx_ir[OP_LSB +: 5];
    assign xm_op        = xm_ir[OP_LSB +: 5];
    assign mw_op        = mw_ir[OP_LSB +: 5];
    assign dx_alu_field = dx_ir[6:2];
    assign fd_rd        = fd_ir[RD_LSB +: REG_W];
    assign fd_rs        = fd_ir[RS_LSB +: REG_W];
    assign fd_rt        = fd_ir[RT_LSB +: REG_W];
    assign dx_rd        = dx_ir[RD_LSB +: REG_W];
    assign mw_rd        = mw_ir[RD_LSB +: REG_W];

    // Datapath controls depend only on the latched IRs, never on the handshake state.
    always_comb begin
        alu_op      = op_uses_imm(dx_op) ? ALU_ADD : dx_alu_field;
        dx_imm_sel  = op_uses_imm(dx_op);
        datamem_we  = (xm_op == OP_SW);
        mw_load_sel = (mw_op == OP_LW);
        regfile_we  = !op_no_regwrite(mw_op);
        sw_fd_sel   = (fd_op == OP_SW);
        wb_rd_zero  = (mw_rd == '0);
    end

    // A load into r0 never creates a dependency since r0 is never written.
    always_comb begin
        load_use = 1'b0;
        if ((dx_op == OP_LW) && (dx_rd != '0)) begin
            if (!op_is_jump(fd_op) && (fd_rs == dx_rd)) begin
                load_use = 1'b1;
            end
            if ((fd_op == OP_R) && (fd_rt == dx_rd)) begin
                load_use = 1'b1;
            end
            if (op_reads_rd(fd_op) && (fd_rd == dx_rd)) begin
                load_use = 1'b1;
            end
        end
    end

    assign dx_is_md  = (dx_op == OP_R) &&
                       ((dx_alu_field == ALU_MULT) || (dx_alu_field == ALU_DIV));
    assign start_req = dx_is_md && !branch_taken;

    // Flush beats the load-use stall; the multicycle stall holds regardless and owns DX, so no bubble then.
    assign flush     = branch_taken;
    assign stall_fd  = md_busy || (load_use && !branch_taken);
    assign bubble_dx = load_use && !branch_taken && !md_busy;

    md_handshake_fsm #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_fsm (
        .clock       (clock),
        .reset       (reset),
        .start_req   (start_req),
        .md_ready    (md_ready),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .md_wb_valid (md_wb_valid),
        .md_error    (md_error)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall_fd && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Next-generation control/hazard unit for the 5-stage pipeline (F/D/X/M/W).
- Decodes the latched FD/DX/XM/MW instruction words into datapath controls.
- Adds three sequential functions:
  - load-use stall/bubble insertion;
  - branch/jump flush;
  - a multicycle mult/div handshake FSM with timeout and a saturating stall-cycle counter.
- Instruction width, register-address width and the timeout are parametrised.

Parameters:
- INSN_W, 32: instruction word width. Opcode = [INSN_W-1 -: 5].
- REG_W, 5: register address width. rd = [26:22], rs = [21:17], rt = [16:12] at the defaults; fields shift with INSN_W.
- MD_TIMEOUT, 64: maximum BUSY cycles before md_error is raised.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low.
- fd_ir, in, INSN_W: F/D instruction.
- dx_ir, in, INSN_W: D/X instruction.
- xm_ir, in, INSN_W: X/M instruction.
- mw_ir, in, INSN_W: M/W instruction.
- branch_taken, in, 1: X-stage branch/jump resolved taken.
- md_ready, in, 1: multdiv unit result valid.
- alu_op, out, 5: 0 for addi/lw/sw, else dx_ir[6:2].
- dx_imm_sel, out, 1: ALU B operand = immediate (addi/lw/sw in DX).
- datamem_we, out, 1: sw in XM.
- mw_load_sel, out, 1: writeback from memory (lw in MW).
- regfile_we, out, 1: MW writes the register file.
- sw_fd_sel, out, 1: sw in FD (read rd as source).
- wb_rd_zero, out, 1: MW rd == 0 (suppresses write).
- stall_fd, out, 1: hold the PC and the FD latch.
- bubble_dx, out, 1: load a nop into DX.
- flush, out, 1: nop the FD and DX latches.
- md_start, out, 1: one-cycle mult/div start.
- md_busy, out, 1: FSM in BUSY.
- md_wb_valid, out, 1: one-cycle result-valid to the XM latch.
- md_error, out, 1: sticky timeout flag.
- stall_count, out, STALL_CNT_W: saturating count of stalled cycles.

Behaviour:
- **Opcodes (5 bits):**
  - R=00000, j=00001, bne=00010, jal=00011, jr=00100, addi=00101, blt=00110, sw=00111, lw=01000, setx=10101, bex=10110.
  - In R-type, ALU op mult=00110, div=00111.
- **Decode outputs:** combinational from the IR inputs, independent of the FSM.
  - regfile_we = 0 when MW holds sw, j, jr, bne, blt or bex. Otherwise it is 1, including rd==0; wb_rd_zero gates that case.
- **Load-use hazard:** DX is lw with rd != 0, and FD reads that rd.
  - FD reads rs for all non-jump types, rt for R-type, rd for sw/bne/blt/jr.
  - Response: stall_fd=1 and bubble_dx=1 for exactly one cycle (the next cycle the lw is in XM and the hazard clears).
- **Flush:** flush = branch_taken, combinational, one cycle. When flush and the load-use hazard coincide, flush wins and stall_fd=bubble_dx=0.
- **MD FSM states:**
  - IDLE → BUSY when DX is an R-type mult/div and flush=0. md_start=1 for that single cycle (registered pulse, asserted in the first BUSY cycle).
  - BUSY: stall_fd=1 and md_busy=1, DX is held, bubble_dx=0, and the timeout counter increments.
  - BUSY → DONE on md_ready. md_wb_valid=1 for the one DONE cycle; stall_fd is released in DONE.
  - DONE → IDLE unconditionally.
  - BUSY → IDLE when the counter reaches MD_TIMEOUT-1 without md_ready. md_error is set and stays set until reset; md_wb_valid is not pulsed.
  - md_ready outside BUSY is ignored.
  - A new mult/div in DX in the DONE cycle is not accepted until IDLE.
- **stall_count:** increments each cycle stall_fd=1. It saturates at all-ones and does not wrap.
- **Reset (async, low):**
  - FSM to IDLE; timeout counter, stall_count and md_error to 0.
  - md_start, md_busy and md_wb_valid go to 0 immediately.
  - Reset mid-BUSY abandons the operation with no wb pulse.
  - Decode outputs stay combinational from the IRs.

Decomposition:
- Package pipe_ctrl_pkg: opcode constants, ALU-op constants (ADD=0, MULT=6, DIV=7), FSM state encoding (IDLE/BUSY/DONE, 2 bits), field-offset functions of INSN_W.
- Sub-module md_handshake_fsm: FSM, timeout counter and md_error. The top level holds the decode, hazard logic and stall counter.

Test Plan:
- Decode: dx_ir = lw (opcode 01000), xm_ir = sw (00111), mw_ir = bex (10110) → alu_op=0, dx_imm_sel=1, datamem_we=1, regfile_we=0; mw_ir = R add with rd=0 → regfile_we=1, wb_rd_zero=1.
- Load-use: DX = lw r3, FD = add r4,r3,r5 → stall_fd=bubble_dx=1 for one cycle, stall_count=1. Repeat with DX = lw r0 → no stall.
- Flush priority: load-use hazard plus branch_taken=1 in the same cycle → flush=1, stall_fd=0, bubble_dx=0, stall_count unchanged.
- Mult handshake: DX = mult, md_ready after 5 cycles → md_start one pulse, md_busy and stall_fd high for those cycles, md_wb_valid one pulse, then IDLE, stall_count=5.
- Timeout: DX = div, md_ready never asserted, MD_TIMEOUT=8 → after 8 BUSY cycles return to IDLE, md_error=1 sticky, no md_wb_valid; a later md_ready is ignored.
- Reset mid-BUSY and saturation: reset low during BUSY → outputs cleared asynchronously. With STALL_CNT_W=3 and 10 stall cycles → stall_count holds at 7.
